// File: rtl/adc_trig_pkg.sv
// ============================================================================
// Module   : adc_trig_pkg
// Purpose  : Shared state, mode and side encodings for the analog edge trigger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_trig_pkg;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_DISARMED = 3'd0;
    localparam fsm_state_t ST_PRIME    = 3'd1;
    localparam fsm_state_t ST_READY    = 3'd2;
    localparam fsm_state_t ST_QUALIFY  = 3'd3;
    localparam fsm_state_t ST_FIRE     = 3'd4;
    localparam fsm_state_t ST_HOLDOFF  = 3'd5;

    localparam logic [1:0] MODE_RISE   = 2'b00;
    localparam logic [1:0] MODE_FALL   = 2'b01;
    localparam logic [1:0] MODE_EITHER = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam logic SIDE_LOW  = 1'b0;
    localparam logic SIDE_HIGH = 1'b1;

    // Length registers treat 0 as 1 so a zero write never stalls the FSM.
    function automatic logic [7:0] eff_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adc_level_classify.sv
// ============================================================================
// Module   : adc_level_classify
// Purpose  : Registers the ADC sample and classifies it against both thresholds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_level_classify #(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic [DATA_W-1:0] thresh_hi,
    input  logic [DATA_W-1:0] thresh_lo,
    output logic              above,
    output logic              below,
    output logic              config_err
);

    logic [DATA_W-1:0] r_d;
    logic              r_cfg_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d       <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_d       <= adc_data;
            r_cfg_err <= (thresh_lo > thresh_hi);
        end
    end

    // Live thresholds: a change applies to the very next registered sample.
    assign above      = (r_d >= thresh_hi);
    assign below      = (r_d <= thresh_lo);
    assign config_err = r_cfg_err;

endmodule

`default_nettype wire

// File: rtl/adc_edge_trigger.sv
// ============================================================================
// Module   : adc_edge_trigger
// Purpose  : Qualified threshold-crossing trigger with pulse stretch and holdoff.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_edge_trigger
    import adc_trig_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              arm,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] thresh_hi,
    input  logic [DATA_W-1:0] thresh_lo,
    input  logic [7:0]        qual_len,
    input  logic [7:0]        pulse_len,
    input  logic [HOLD_W-1:0] holdoff,
    output logic              trig_out,
    output logic              armed_o,
    output logic [15:0]       trig_count,
    output logic              config_err
);

    logic              w_above;
    logic              w_below;
    logic              w_cfg_err;

    fsm_state_t        r_state;
    fsm_state_t        w_state_nxt;
    logic              r_side;
    logic              w_side_nxt;
    logic [7:0]        r_qcnt;
    logic [7:0]        w_qcnt_nxt;
    logic [7:0]        r_pcnt;
    logic [7:0]        w_pcnt_nxt;
    logic [HOLD_W-1:0] r_hcnt;
    logic [HOLD_W-1:0] w_hcnt_nxt;
    logic [1:0]        r_mode;
    logic              r_arm;
    logic              r_trig;
    logic [15:0]       r_trig_count;

    logic              w_en;
    logic              w_mode_chg;
    logic              w_target_hit;
    logic              w_fire_entry;
    logic [7:0]        w_qual_eff;
    logic [7:0]        w_pulse_eff;
    logic [8:0]        w_qcnt_inc;
    logic [8:0]        w_pcnt_inc;
    logic [HOLD_W:0]   w_hcnt_inc;

    adc_level_classify #(
        .DATA_W (DATA_W)
    ) u_classify (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_data   (adc_data),
        .thresh_hi  (thresh_hi),
        .thresh_lo  (thresh_lo),
        .above      (w_above),
        .below      (w_below),
        .config_err (w_cfg_err)
    );

    assign w_en         = arm && (mode != MODE_OFF) && !w_cfg_err;
    assign w_mode_chg   = (r_state != ST_DISARMED) && (mode != r_mode);
    assign w_target_hit = (r_side == SIDE_LOW) ? w_above : w_below;
    assign w_qual_eff   = eff_len(qual_len);
    assign w_pulse_eff  = eff_len(pulse_len);
    assign w_qcnt_inc   = {1'b0, r_qcnt} + 9'd1;
    assign w_pcnt_inc   = {1'b0, r_pcnt} + 9'd1;
    assign w_hcnt_inc   = {1'b0, r_hcnt} + {{HOLD_W{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt = r_state;
        w_side_nxt  = r_side;
        w_qcnt_nxt  = r_qcnt;
        w_pcnt_nxt  = r_pcnt;
        w_hcnt_nxt  = r_hcnt;
        if (!w_en || w_mode_chg) begin
            w_state_nxt = w_en ? ST_PRIME : ST_DISARMED;
            w_side_nxt  = SIDE_LOW;
            w_qcnt_nxt  = '0;
            w_pcnt_nxt  = '0;
            w_hcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_DISARMED: w_state_nxt = ST_PRIME;
                ST_PRIME: begin
                    // Either mode picks low on a tie so the target becomes high.
                    if ((mode != MODE_FALL) && w_below) begin
                        w_side_nxt  = SIDE_LOW;
                        w_state_nxt = ST_READY;
                    end else if ((mode != MODE_RISE) && w_above) begin
                        w_side_nxt  = SIDE_HIGH;
                        w_state_nxt = ST_READY;
                    end
                end
                ST_READY: begin
                    if (w_target_hit) begin
                        w_qcnt_nxt  = 8'd1;
                        w_state_nxt = (w_qual_eff == 8'd1) ? ST_FIRE : ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (!w_target_hit) begin
                        w_qcnt_nxt  = '0;
                        w_state_nxt = ST_READY;
                    end else if (w_qcnt_inc >= {1'b0, w_qual_eff}) begin
                        w_qcnt_nxt  = '0;
                        w_state_nxt = ST_FIRE;
                    end else begin
                        w_qcnt_nxt  = w_qcnt_inc[7:0];
                    end
                end
                ST_FIRE: begin
                    w_qcnt_nxt = '0;
                    if (w_pcnt_inc >= {1'b0, w_pulse_eff}) begin
                        w_pcnt_nxt  = '0;
                        w_hcnt_nxt  = '0;
                        w_state_nxt = (holdoff == '0) ? ST_PRIME : ST_HOLDOFF;
                    end else begin
                        w_pcnt_nxt  = w_pcnt_inc[7:0];
                    end
                end
                ST_HOLDOFF: begin
                    if (w_hcnt_inc >= {1'b0, holdoff}) begin
                        w_hcnt_nxt  = '0;
                        w_state_nxt = ST_PRIME;
                    end else begin
                        w_hcnt_nxt  = w_hcnt_inc[HOLD_W-1:0];
                    end
                end
                default: w_state_nxt = ST_DISARMED;
            endcase
        end
    end

    assign w_fire_entry = (w_state_nxt == ST_FIRE) && (r_state != ST_FIRE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_DISARMED;
            r_side       <= SIDE_LOW;
            r_qcnt       <= '0;
            r_pcnt       <= '0;
            r_hcnt       <= '0;
            r_mode       <= MODE_RISE;
            r_arm        <= 1'b0;
            r_trig       <= 1'b0;
            r_trig_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_side  <= w_side_nxt;
            r_qcnt  <= w_qcnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_mode  <= mode;
            r_arm   <= arm;
            r_trig  <= (w_state_nxt == ST_FIRE);
            if (arm && !r_arm) begin
                r_trig_count <= '0;
            end else if (w_fire_entry && (r_trig_count != 16'hFFFF)) begin
                r_trig_count <= r_trig_count + 16'd1;
            end
        end
    end

    assign trig_out   = r_trig;
    assign armed_o    = (r_state == ST_PRIME) || (r_state == ST_READY) ||
                        (r_state == ST_QUALIFY);
    assign trig_count = r_trig_count;
    assign config_err = w_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_adc_edge_trigger.sv
// ============================================================================
// Module   : tb_adc_edge_trigger
// Purpose  : Directed and randomized checks of adc_edge_trigger against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_edge_trigger;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  adc_data;
    logic        arm;
    logic [1:0]  mode;
    logic [9:0]  thresh_hi;
    logic [9:0]  thresh_lo;
    logic [7:0]  qual_len;
    logic [7:0]  pulse_len;
    logic [15:0] holdoff;
    logic        trig_out;
    logic        armed_o;
    logic [15:0] trig_count;
    logic        config_err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int hi_cycles = 0;
    int s_cyc = -1;
    bit last_trig = 1'b0;

    // Reference model: sample-stream view (priming, run length, countdowns).
    bit         m_active, m_have_side, m_side_low, m_err, m_armq;
    int         m_run, m_fire_left, m_dead_left, m_count;
    logic [9:0] m_d;
    logic [1:0] m_modeq;

    always #5 clk = ~clk;

    adc_edge_trigger #(
        .DATA_W (10),
        .HOLD_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_data   (adc_data),
        .arm        (arm),
        .mode       (mode),
        .thresh_hi  (thresh_hi),
        .thresh_lo  (thresh_lo),
        .qual_len   (qual_len),
        .pulse_len  (pulse_len),
        .holdoff    (holdoff),
        .trig_out   (trig_out),
        .armed_o    (armed_o),
        .trig_count (trig_count),
        .config_err (config_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_have_side = 1'b0;
        m_run       = 0;
        m_fire_left = 0;
        m_dead_left = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_active = 1'b0;
        m_side_low = 1'b0;
        m_err = 1'b0;
        m_armq = 1'b0;
        m_count = 0;
        m_d = '0;
        m_modeq = 2'b00;
    endtask

    task automatic model_edge();
        int eq, ep;
        bit en, above, below, tgt;
        eq = (qual_len == 8'd0) ? 1 : int'(qual_len);
        ep = (pulse_len == 8'd0) ? 1 : int'(pulse_len);
        above = (m_d >= thresh_hi);
        below = (m_d <= thresh_lo);
        en = arm && (mode != 2'b11) && !m_err;
        if (!en) begin
            m_active = 1'b0;
            model_clear();
        end else if (m_active && (mode != m_modeq)) begin
            model_clear();
        end else if (!m_active) begin
            m_active = 1'b1;
            model_clear();
        end else if (m_fire_left > 0) begin
            m_fire_left--;
            if (m_fire_left == 0) m_dead_left = int'(holdoff);
        end else if (m_dead_left > 0) begin
            m_dead_left--;
        end else if (!m_have_side) begin
            if (mode == 2'b00 && below) begin
                m_have_side = 1'b1; m_side_low = 1'b1;
            end else if (mode == 2'b01 && above) begin
                m_have_side = 1'b1; m_side_low = 1'b0;
            end else if (mode == 2'b10 && (below || above)) begin
                m_have_side = 1'b1; m_side_low = below;
            end
        end else begin
            tgt = m_side_low ? above : below;
            if (tgt) begin
                m_run++;
                if (m_run >= eq) begin
                    m_run = 0;
                    m_fire_left = ep;
                    m_have_side = 1'b0;
                    if (m_count < 65535) m_count++;
                end
            end else begin
                m_run = 0;
            end
        end
        if (arm && !m_armq) m_count = 0;
        m_d = adc_data;
        m_err = (thresh_lo > thresh_hi);
        m_modeq = mode;
        m_armq = arm;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check_val("trig", trig_out, (m_fire_left > 0));
        check_val("armed", armed_o, m_active && (m_fire_left == 0) && (m_dead_left == 0));
        check_val("count", trig_count, m_count);
        check_val("cfg_err", config_err, m_err);
        if (trig_out && !last_trig && rise_cyc < 0) rise_cyc = cyc;
        if (trig_out) hi_cycles++;
        last_trig = trig_out;
    endtask

    task automatic configure(input logic [1:0] md, input int hi, input int lo,
                             input int q, input int p, input int h);
        arm = 1'b0;
        step();
        mode = md;
        thresh_hi = 10'(hi);
        thresh_lo = 10'(lo);
        qual_len = 8'(q);
        pulse_len = 8'(p);
        holdoff = 16'(h);
        step();
        step();
    endtask

    task automatic arm_with(input int v);
        adc_data = 10'(v);
        arm = 1'b1;
        repeat (3) step();
        rise_cyc = -1;
        hi_cycles = 0;
        s_cyc = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got 0, expected 1 (bench did not finish)");
        $fatal(1, "timeout");
    end

    initial begin
        int q_seq[8];
        int v, lo, hi, r;
        q_seq = '{300, 650, 650, 500, 650, 650, 650, 650};
        reset_n = 1'b0;
        adc_data = '0; arm = 1'b0; mode = 2'b00;
        thresh_hi = 10'd600; thresh_lo = 10'd400;
        qual_len = 8'd1; pulse_len = 8'd1; holdoff = '0;
        model_reset();
        #12;
        check_val("rst0_trig", trig_out, 0);
        check_val("rst0_armed", armed_o, 0);
        check_val("rst0_count", trig_count, 0);
        check_val("rst0_cfg", config_err, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Rising ramp, single qualifying sample
        configure(2'b00, 600, 400, 1, 3, 0);
        arm_with(300);
        for (int s = 300; s <= 700; s += 50) begin
            adc_data = 10'(s);
            if (s >= 600 && s_cyc < 0) s_cyc = cyc + 1;
            step();
        end
        repeat (8) step();
        check_val("ramp_lat", rise_cyc - s_cyc, 1);
        check_val("ramp_width", hi_cycles, 3);
        check_val("ramp_count", trig_count, 1);

        // Qualification aborted by an in-band sample
        configure(2'b00, 600, 400, 4, 3, 0);
        arm_with(300);
        for (int i = 0; i < 8; i++) begin
            adc_data = 10'(q_seq[i]);
            if (i == 4) s_cyc = cyc + 1;
            step();
        end
        repeat (8) step();
        check_val("qual_lat", rise_cyc - s_cyc, 4);
        check_val("qual_count", trig_count, 1);

        // Falling square wave with holdoff swallowing one edge
        configure(2'b01, 600, 400, 1, 2, 10);
        arm_with(800);
        for (int t = 0; t < 40; t++) begin
            adc_data = ((t % 8) < 4) ? 10'd200 : 10'd800;
            step();
        end
        adc_data = 10'd800;
        repeat (4) step();
        check_val("sq_count", trig_count, 3);

        // Either mode: ten crossings, then in-band wobble
        configure(2'b10, 600, 400, 1, 2, 0);
        arm_with(300);
        for (int p = 0; p < 5; p++) begin
            for (int s = 300; s <= 700; s += 50) begin adc_data = 10'(s); step(); end
            for (int s = 650; s >= 350; s -= 50) begin adc_data = 10'(s); step(); end
        end
        adc_data = 10'd300;
        repeat (4) step();
        check_val("either_count", trig_count, 10);
        for (int i = 0; i < 40; i++) begin
            adc_data = 10'(450 + (i % 3) * 50);
            step();
        end
        check_val("band_count", trig_count, 10);

        // Inverted thresholds block arming until corrected
        configure(2'b00, 300, 700, 1, 2, 0);
        arm_with(500);
        repeat (3) step();
        check_val("cfgerr_flag", config_err, 1);
        check_val("cfgerr_armed", armed_o, 0);
        check_val("cfgerr_trig", trig_out, 0);
        thresh_hi = 10'd600;
        thresh_lo = 10'd400;
        step();
        step();
        check_val("cfgfix_armed", armed_o, 1);

        // Disarm in the middle of a long pulse, then re-arm
        configure(2'b00, 600, 400, 1, 20, 0);
        arm_with(300);
        adc_data = 10'd700;
        repeat (6) step();
        check_val("fire_hi", trig_out, 1);
        arm = 1'b0;
        step();
        check_val("armdrop_trig", trig_out, 0);
        arm = 1'b1;
        step();
        check_val("rearm_clr", trig_count, 0);

        // Asynchronous reset during qualification
        configure(2'b00, 600, 400, 8, 2, 0);
        arm_with(300);
        adc_data = 10'd700;
        repeat (12) step();
        adc_data = 10'd300;
        repeat (3) step();
        adc_data = 10'd700;
        repeat (4) step();
        check_val("pre_rst_armed", armed_o, 1);
        check_val("pre_rst_count", trig_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_trig", trig_out, 0);
        check_val("rst_armed", armed_o, 0);
        check_val("rst_count", trig_count, 0);
        check_val("rst_cfg", config_err, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // Randomized segments
        for (int seg = 0; seg < 8; seg++) begin
            lo = $urandom_range(100, 600);
            hi = lo + $urandom_range(0, 300);
            r = $urandom_range(0, 7);
            if (r == 0) hi = lo;
            if (r == 1) begin v = hi; hi = lo; lo = v; end
            configure(2'($urandom_range(0, 3)), hi, lo, $urandom_range(0, 5),
                      $urandom_range(0, 4), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 12));
            v = $urandom_range(0, 1023);
            arm_with(v);
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    v = $urandom_range(0, 1023);
                end else begin
                    v = v + $urandom_range(0, 80) - 40;
                    if (v < 0) v = 0;
                    if (v > 1023) v = 1023;
                end
                adc_data = 10'(v);
                if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 2));
                if ($urandom_range(0, 199) == 0) thresh_lo = 10'($urandom_range(100, 600));
                arm = ($urandom_range(0, 119) != 0);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
